// File: rtl/wave_capture_pkg.sv
// Shared types and constants for the waveform capture block.
// State encoding doubles as the capture_state debug output.
package wave_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      FULL    = 2'd3
   } cap_state_e;

   localparam logic [7:0] OFFSET_XOR = 8'h80;
   localparam int         SAMPLE_MSB = 15;
   localparam int         BYTE_W     = 8;

   function automatic logic [BYTE_W-1:0] to_offset(
      input logic [SAMPLE_MSB:0] s
   );
      return s[SAMPLE_MSB -: BYTE_W] ^ OFFSET_XOR;
   endfunction

   function automatic logic rising_zc(
      input logic [SAMPLE_MSB:0] prev,
      input logic [SAMPLE_MSB:0] cur
   );
      return ($signed(prev) < 0) && ($signed(cur) >= 0);
   endfunction

endpackage

// File: rtl/wave_capture_ram.sv
// Ping-pong trace store: address MSB selects the bank.
// One synchronous write port, one registered read port.
module wave_capture_ram
   import wave_capture_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                we_i,
   input  logic [ADDR_WIDTH:0] waddr_i,
   input  logic [BYTE_W-1:0]   wdata_i,
   input  logic [ADDR_WIDTH:0] raddr_i,
   output logic [BYTE_W-1:0]   rdata_o
);

   localparam int DEPTH = 1 << (ADDR_WIDTH + 1);

   logic [BYTE_W-1:0] mem_q [0:DEPTH-1];
   logic [BYTE_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Only the output register is reset; the array itself is not.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wave_capture.sv
// Rising zero-crossing triggered trace capture into a ping-pong RAM.
// The display reads one bank while the other fills; swap on frame sync.
module wave_capture
   import wave_capture_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  new_sample,
   input  logic [15:0]           sample_in,
   input  logic                  enable,
   input  logic                  frame_sync,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [7:0]            read_data,
   output logic                  new_wave,
   output logic [1:0]            capture_state
);

   cap_state_e            state_q;
   logic [15:0]           prev_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [ADDR_WIDTH-1:0] timeout_q;
   logic                  read_bank_q;
   logic                  new_wave_q;

   logic                  zc;
   logic                  tmo;
   logic                  trig;
   logic                  we;
   logic [ADDR_WIDTH-1:0] waddr;

   assign zc   = rising_zc(prev_q, sample_in);
   assign tmo  = &timeout_q;
   assign trig = new_sample & (zc | tmo);

   // The triggering sample itself is the first byte of the trace.
   always_comb begin
      we    = 1'b0;
      waddr = wr_addr_q;
      if (enable) begin
         unique case (state_q)
            ARMED: begin
               we    = trig;
               waddr = '0;
            end
            CAPTURE: we = new_sample;
            default: we = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         wr_addr_q   <= '0;
         timeout_q   <= '0;
         read_bank_q <= 1'b0;
         new_wave_q  <= 1'b0;
      end else begin
         new_wave_q <= 1'b0;
         if (new_sample) begin
            prev_q <= sample_in;
         end
         if (!enable) begin
            state_q <= IDLE;
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q   <= ARMED;
                  timeout_q <= '0;
               end
               ARMED: begin
                  if (new_sample) begin
                     timeout_q <= timeout_q + ADDR_WIDTH'(1);
                  end
                  if (trig) begin
                     wr_addr_q <= ADDR_WIDTH'(1);
                     state_q   <= CAPTURE;
                  end
               end
               CAPTURE: begin
                  if (new_sample) begin
                     wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                     if (&wr_addr_q) begin
                        state_q <= FULL;
                     end
                  end
               end
               FULL: begin
                  if (frame_sync) begin
                     read_bank_q <= ~read_bank_q;
                     new_wave_q  <= 1'b1;
                     timeout_q   <= '0;
                     state_q     <= ARMED;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   wave_capture_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk_i  (clk),
      .rst_ni (reset),
      .we_i   (we),
      .waddr_i({~read_bank_q, waddr}),
      .wdata_i(to_offset(sample_in)),
      .raddr_i({read_bank_q, read_addr}),
      .rdata_o(read_data)
   );

   assign new_wave      = new_wave_q;
   assign capture_state = state_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed-plus-random bench for wave_capture with a trace-level model.
// Expected traces come from scanning the strobed sample list for the trigger.
module tb_wave_capture;

   localparam int AW = 8;
   localparam int N  = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          new_sample;
   logic [15:0]   sample_in;
   logic          enable;
   logic          frame_sync;
   logic [AW-1:0] read_addr;
   logic [7:0]    read_data;
   logic          new_wave;
   logic [1:0]    capture_state;

   int total = 0;
   int bad   = 0;

   logic [15:0] last_s;
   logic [7:0]  vis  [N];
   logic [7:0]  pend [N];
   logic [15:0] stim [$];

   always #5 clk = ~clk;

   wave_capture #(
      .ADDR_WIDTH(AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .new_sample   (new_sample),
      .sample_in    (sample_in),
      .enable       (enable),
      .frame_sync   (frame_sync),
      .read_addr    (read_addr),
      .read_data    (read_data),
      .new_wave     (new_wave),
      .capture_state(capture_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offset-binary byte from the signed value: floor(v/256) + 128.
   function automatic logic [7:0] to_byte(input logic [15:0] s);
      int v;
      v = $signed(s);
      return 8'((v >>> 8) + 128);
   endfunction

   // Index into stim of the sample that starts the trace.
   function automatic int trig_idx(input logic [15:0] prev);
      logic [15:0] p;
      for (int i = 0; i < stim.size(); i++) begin
         p = (i == 0) ? prev : stim[i-1];
         if (i == N - 1) return i;
         if ($signed(p) < 0 && $signed(stim[i]) >= 0) return i;
      end
      return -1;
   endfunction

   task automatic send(input logic [15:0] s);
      new_sample = 1'b1;
      sample_in  = s;
      tick();
      new_sample = 1'b0;
      frame_sync = 1'b0;
      sample_in  = 16'($urandom);
      last_s     = s;
      repeat ($urandom_range(0, 1)) tick();
   endtask

   task automatic rand_stim(input int n);
      stim = {};
      for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
   endtask

   task automatic capture(input string tag, input int fs_at,
                          input int stop_at, input logic fs_last);
      int t;
      int last;
      t = trig_idx(last_s);
      for (int k = 0; k < N; k++) pend[k] = to_byte(stim[t+k]);
      last = (stop_at >= 0) ? t + stop_at : t + N - 1;
      for (int i = 0; i <= last; i++) begin
         if (i == last && stop_at >= 0) enable = 1'b0;
         if (i == last && fs_last) frame_sync = 1'b1;
         send(stim[i]);
         if (i == t - 1) chk({tag, ".armed"}, capture_state, 1);
         if (i == t) chk({tag, ".trig"}, capture_state, 2);
         if (stop_at < 0 && i == t + N - 2)
            chk({tag, ".cap_end"}, capture_state, 2);
         if (fs_at >= 0 && i == t + fs_at) begin
            frame_sync = 1'b1;
            tick();
            frame_sync = 1'b0;
            chk({tag, ".fs_nw"}, new_wave, 0);
            chk({tag, ".fs_st"}, capture_state, 2);
            read_addr = 3;
            tick();
            chk({tag, ".fs_rd"}, read_data, vis[3]);
         end
      end
      if (stop_at >= 0) begin
         chk({tag, ".idle"}, capture_state, 0);
      end else begin
         chk({tag, ".full"}, capture_state, 3);
         chk({tag, ".full_nw"}, new_wave, 0);
      end
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < N; a++) begin
         read_addr = AW'(a);
         tick();
         chk({tag, ".rd"}, read_data, vis[a]);
      end
   endtask

   task automatic swap(input string tag);
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      chk({tag, ".nw"}, new_wave, 1);
      chk({tag, ".sw_st"}, capture_state, 1);
      vis = pend;
      read_addr = '0;
      tick();
      chk({tag, ".nw_off"}, new_wave, 0);
      chk({tag, ".rd0"}, read_data, vis[0]);
      read_all(tag);
   endtask

   initial begin
      reset      = 1'b0;
      new_sample = 1'b0;
      sample_in  = '0;
      enable     = 1'b0;
      frame_sync = 1'b0;
      read_addr  = '0;
      last_s     = '0;
      repeat (3) tick();
      chk("rst.st", capture_state, 0);
      chk("rst.nw", new_wave, 0);
      chk("rst.rd", read_data, 0);
      reset = 1'b1;
      tick();
      chk("rst.idle", capture_state, 0);
      enable = 1'b1;
      tick();
      chk("en.armed", capture_state, 1);

      // Negative run, crossing -100 -> +100 at sample 37
      stim = {};
      for (int i = 0; i < 36; i++)
         stim.push_back(16'(-int'($urandom_range(1, 30000))));
      stim.push_back(16'hFF9C);
      stim.push_back(16'd100);
      for (int i = 0; i < N; i++) stim.push_back(16'($urandom));
      capture("t1", -1, -1, 1'b0);
      repeat (5) tick();
      chk("t1.hold_st", capture_state, 3);
      chk("t1.hold_nw", new_wave, 0);
      swap("t1");
      read_addr = '0;
      tick();
      chk("t1.a0", read_data, 8'h80);

      // Constant input: only the timeout can trigger
      enable = 1'b0;
      tick();
      chk("t2.idle", capture_state, 0);
      send(16'h1234);
      chk("t2.idle2", capture_state, 0);
      enable = 1'b1;
      tick();
      chk("t2.armed", capture_state, 1);
      stim = {};
      for (int i = 0; i < 2 * N; i++) stim.push_back(16'h1234);
      capture("t2", -1, -1, 1'b0);
      swap("t2");
      read_addr = AW'(N - 1);
      tick();
      chk("t2.last", read_data, 8'h92);

      // frame_sync during capture is ignored
      rand_stim(2 * N + 8);
      capture("t3", 99, -1, 1'b0);
      swap("t3");

      // enable dropped mid-capture discards the partial trace
      rand_stim(2 * N + 8);
      capture("t4", -1, 50, 1'b0);
      read_all("t4.keep");
      enable = 1'b1;
      tick();
      chk("t4.rearm", capture_state, 1);

      // Final write coincides with frame_sync: no swap yet
      stim = {};
      for (int i = 0; i < 5; i++)
         stim.push_back(16'(-int'($urandom_range(1, 30000))));
      for (int i = 0; i < 2 * N; i++) stim.push_back(16'($urandom));
      capture("t5", -1, -1, 1'b1);
      read_addr = 7;
      tick();
      chk("t5.noswap", read_data, vis[7]);
      chk("t5.st", capture_state, 3);
      swap("t5");

      // Trigger condition while enable drops: IDLE wins
      send(16'hFF00);
      chk("t6.armed", capture_state, 1);
      enable = 1'b0;
      send(16'h0100);
      chk("t6.idle", capture_state, 0);
      enable = 1'b1;
      tick();
      chk("t6.rearm", capture_state, 1);

      // enable fall and frame_sync together while FULL
      rand_stim(2 * N + 8);
      capture("t7", -1, -1, 1'b0);
      enable     = 1'b0;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      chk("t7.idle", capture_state, 0);
      chk("t7.nw", new_wave, 0);
      for (int a = 0; a < 16; a++) begin
         read_addr = AW'(a);
         tick();
         chk("t7.keep", read_data, vis[a]);
      end

      // Asynchronous reset mid-capture
      enable = 1'b1;
      tick();
      rand_stim(2 * N + 8);
      begin
         int t;
         t = trig_idx(last_s);
         for (int i = 0; i <= t + 20; i++) send(stim[i]);
      end
      chk("t8.cap", capture_state, 2);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("t8.st", capture_state, 0);
      chk("t8.nw", new_wave, 0);
      chk("t8.rd", read_data, 0);
      reset = 1'b1;
      tick();
      chk("t8.armed", capture_state, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
